mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB boundary. It consumes the M-stage control (RegWriteM, MemWriteM, ResultSrcM) and datapath values, and runs a request/ready handshake with a variable-latency data memory. While the access is outstanding it stalls the upstream pipeline. It then registers the W-stage control and data, inserting bubbles during stalls.

## Interface
- MAX_WAIT, 15: maximum wait cycles after the request cycle before the access is aborted (1..255).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- RegWriteM  in  1  register write enable from EX/MEM.
- MemWriteM  in  1  store request from EX/MEM.
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4; 11 treated as 00.
- ALUResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data.
- RdM  in  5  destination register.
- PCPlus4M  in  32  PC+4 of the M-stage instruction.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  32  equals ALUResultM.
- dmem_wdata  out  32  equals WriteDataM.
- dmem_ready  in  1  memory accepts/completes the access this cycle.
- dmem_rdata  in  32  load data; valid when dmem_ready=1.
- StallM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- RegWriteW, ResultSrcW[1:0], RdW[4:0], ALUResultW[31:0], ReadDataW[31:0], PCPlus4W[31:0]  out  W-stage register.
- BusErr  out  1  sticky timeout flag.

## Operation
- Access: load = (ResultSrcM==01), store = MemWriteM. If both are set, it is a store; the W stage then writes back ALUResultW as for ResultSrcM=00.
- FSM states: IDLE, WAIT.
  - IDLE, access, dmem_ready=1: completes in one cycle; stay IDLE.
  - IDLE, access, dmem_ready=0: go to WAIT; clear the wait counter.
  - WAIT, dmem_ready=1: complete; go to IDLE.
  - WAIT, counter==MAX_WAIT and dmem_ready=0: abort; set BusErr; go to IDLE.
  - Otherwise in WAIT: increment the counter.
- dmem_req = reset_n & ((IDLE & access) | WAIT). This is combinational, so zero-wait memory costs no cycle.
- dmem_we = MemWriteM. dmem_addr and dmem_wdata are driven straight from the M-stage inputs. These inputs stay stable during a transaction because EX/MEM is frozen by StallM.
- StallM = dmem_req & ~dmem_ready & ~abort, where abort means WAIT & counter==MAX_WAIT.
- W-register update on every clock edge:
  - StallM=1: load a bubble (RegWriteW=0, ResultSrcW=00); the data fields hold their previous values.
  - Completion or non-access: capture the M-stage fields. ReadDataW takes dmem_rdata on a completing load and holds otherwise.
  - Abort: capture the fields with RegWriteW forced to 0, so the faulted instruction is retired without writeback.
- A store with RegWriteM=1 is passed through unchanged; the decoder normally clears it.
- BusErr stays set until reset.
- The counter is 8 bits wide and is never allowed to wrap.

## Timing
- Reset (reset_n low, asynchronous):
  - State = IDLE and counter = 0.
  - All W outputs = 0 and BusErr = 0.
  - dmem_req = 0 and StallM = 0 while reset_n is low.
- Reset asserted mid-WAIT abandons the transaction. After release the FSM is in IDLE; the memory must tolerate the dropped request.
- Handshake: an access completes on exactly the one edge where dmem_req & dmem_ready is high. dmem_req never drops before that edge except on abort or reset.
- Latency:
  - Non-access or zero-wait access: W fields are valid one cycle after M.
  - Access with N wait cycles (N ≤ MAX_WAIT): StallM is high for N cycles, and the W result appears on the edge after ready.
- Abort: StallM is high for MAX_WAIT+1 cycles. On the abort edge the W stage captures with RegWriteW=0 and BusErr rises.
- Back-to-back accesses: the next access can issue in IDLE on the cycle right after completion, with no dead cycle.
- dmem_ready asserted while dmem_req=0 is ignored.

## Test plan
- Zero-wait load: ResultSrcM=01, ALUResultM=0x100, dmem_ready=1, dmem_rdata=0xCAFEBABE → StallM stays 0; next edge gives ReadDataW=0xCAFEBABE, ResultSrcW=01, RegWriteW=1.
- 3-wait store: MemWriteM=1, addr 0x40, wdata 0x12345678, ready on the 4th request cycle → StallM=1 for 3 cycles; dmem_we=1 with stable addr/wdata; 3 bubbles then the store in W; 4 edges in total with the store retired on the 4th.
- Timeout with MAX_WAIT=4: load with dmem_ready held at 0 → StallM high for 5 cycles; on the abort edge RegWriteW=0 and BusErr=1; BusErr still 1 after 10 more idle cycles.
- ALU/JAL pass-through: ResultSrcM=10, PCPlus4M=0x2004, RdM=1 → dmem_req=0; next cycle PCPlus4W=0x2004, RdW=1, RegWriteW=1.
- Reset mid-WAIT: load waiting 2 cycles, then reset_n pulled low → dmem_req, StallM and all W outputs drop to 0 immediately; after release, a zero-wait load completes normally.
- Back-to-back zero-wait load then store: retire on consecutive cycles, with no StallM and no bubble.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : M-stage inputs, data-memory handshake and W-stage outputs
//               of the memory-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_lsu_if;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  logic        StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic        BusErr;

  // Pipeline and memory side.
  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M,
    output dmem_ready, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  StallM, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, BusErr
  );

  // Load/store unit side.
  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M,
    input  dmem_ready, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output StallM, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, BusErr
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-stage LSU with variable-latency req/ready handshake,
//               pipeline stall, timeout abort and MEM/WB register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  mem_stage_lsu_if.slave   bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       is_store, is_load, access;
  logic       in_wait, req, abort, stall, complete;
  logic [1:0] wb_src;

  logic        regwrite_q;
  logic [1:0]  resultsrc_q;
  logic [4:0]  rd_q;
  logic [31:0] aluresult_q;
  logic [31:0] readdata_q;
  logic [31:0] pcplus4_q;
  logic        buserr_q;

  // A store wins over a simultaneous load encoding.
  assign is_store = bus.MemWriteM;
  assign is_load  = ~bus.MemWriteM & (bus.ResultSrcM == 2'b01);
  assign access   = is_store | is_load;
  assign in_wait  = (state_q == S_WAIT);

  // Stores and the reserved 11 encoding write back the ALU result.
  assign wb_src = (is_store || bus.ResultSrcM == 2'b11) ? 2'b00 : bus.ResultSrcM;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access && !bus.dmem_ready) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        if (bus.dmem_ready || cnt_q == C_MAX_WAIT) begin
          state_d = S_IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req      = reset_n & ((~in_wait & access) | in_wait);
    abort    = in_wait & (cnt_q == C_MAX_WAIT) & ~bus.dmem_ready;
    stall    = req & ~bus.dmem_ready & ~abort;
    complete = req & bus.dmem_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      rd_q        <= 5'd0;
      aluresult_q <= 32'd0;
      readdata_q  <= 32'd0;
      pcplus4_q   <= 32'd0;
      buserr_q    <= 1'b0;
    end else if (stall) begin
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
    end else begin
      regwrite_q  <= bus.RegWriteM & ~abort;
      resultsrc_q <= wb_src;
      rd_q        <= bus.RdM;
      aluresult_q <= bus.ALUResultM;
      pcplus4_q   <= bus.PCPlus4M;
      if (complete && is_load) begin
        readdata_q <= bus.dmem_rdata;
      end
      if (abort) begin
        buserr_q <= 1'b1;
      end
    end
  end

  assign bus.dmem_req   = req;
  assign bus.dmem_we    = bus.MemWriteM;
  assign bus.dmem_addr  = bus.ALUResultM;
  assign bus.dmem_wdata = bus.WriteDataM;
  assign bus.StallM     = stall;
  assign bus.RegWriteW  = regwrite_q;
  assign bus.ResultSrcW = resultsrc_q;
  assign bus.RdW        = rd_q;
  assign bus.ALUResultW = aluresult_q;
  assign bus.ReadDataW  = readdata_q;
  assign bus.PCPlus4W   = pcplus4_q;
  assign bus.BusErr     = buserr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Directed plus randomized transactions against a
//               transaction-level model of the memory-stage LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;
  localparam int MAXW = 4;

  logic clk;
  logic reset_n;
  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.MAX_WAIT(MAXW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Expected W-stage state, updated once per retired instruction.
  logic        e_rw;
  logic [1:0]  e_rs;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_rdata, e_pc;
  logic        e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_rw = 1'b0; e_rs = 2'b00; e_rd = 5'd0;
    e_alu = 32'd0; e_rdata = 32'd0; e_pc = 32'd0; e_err = 1'b0;
  endtask

  task automatic check_w(input string tag);
    chk({tag, ".RegWriteW"},  32'(bus.RegWriteW),  32'(e_rw));
    chk({tag, ".ResultSrcW"}, 32'(bus.ResultSrcW), 32'(e_rs));
    chk({tag, ".RdW"},        32'(bus.RdW),        32'(e_rd));
    chk({tag, ".ALUResultW"}, bus.ALUResultW,      e_alu);
    chk({tag, ".ReadDataW"},  bus.ReadDataW,       e_rdata);
    chk({tag, ".PCPlus4W"},   bus.PCPlus4W,        e_pc);
    chk({tag, ".BusErr"},     32'(bus.BusErr),     32'(e_err));
  endtask

  task automatic drive_m(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc4);
    bus.RegWriteM  = rw;
    bus.MemWriteM  = mw;
    bus.ResultSrcM = rs;
    bus.ALUResultM = alu;
    bus.WriteDataM = wd;
    bus.RdM        = rd;
    bus.PCPlus4M   = pc4;
  endtask

  // One instruction through M; memory answers on request cycle 'lat' (0 = same cycle).
  task automatic run_txn(input string tag, input logic rw, input logic mw,
                         input logic [1:0] rs, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4, input int lat,
                         input logic [31:0] rdata);
    bit access, load, done, aborted, rdy;
    int k;
    access = mw || (rs == 2'b01);
    load   = !mw && (rs == 2'b01);
    @(negedge clk);
    drive_m(rw, mw, rs, alu, wd, rd, pc4);
    aborted = 1'b0;
    if (!access) begin
      bus.dmem_ready = 1'($urandom_range(0, 1));
      bus.dmem_rdata = $urandom();
      #1;
      chk({tag, ".req"},   32'(bus.dmem_req), 32'd0);
      chk({tag, ".stall"}, 32'(bus.StallM),   32'd0);
      @(posedge clk); #1;
    end else begin
      k = 0;
      done = 1'b0;
      while (!done) begin
        if (k > 0) @(negedge clk);
        rdy = (k == lat);
        bus.dmem_ready = rdy;
        bus.dmem_rdata = rdy ? rdata : $urandom();
        #1;
        aborted = !rdy && (k == MAXW + 1);
        chk({tag, ".req"},   32'(bus.dmem_req), 32'd1);
        chk({tag, ".we"},    32'(bus.dmem_we),  32'(mw));
        chk({tag, ".addr"},  bus.dmem_addr,     alu);
        chk({tag, ".wdata"}, bus.dmem_wdata,    wd);
        chk({tag, ".stall"}, 32'(bus.StallM),   32'(!rdy && !aborted));
        @(posedge clk); #1;
        if (!rdy && !aborted) begin
          chk({tag, ".bubble_rw"}, 32'(bus.RegWriteW),  32'd0);
          chk({tag, ".bubble_rs"}, 32'(bus.ResultSrcW), 32'd0);
          chk({tag, ".bubble_alu"}, bus.ALUResultW,     e_alu);
        end else begin
          done = 1'b1;
        end
        k++;
      end
    end
    e_rw  = aborted ? 1'b0 : rw;
    e_rs  = (mw || rs == 2'b11) ? 2'b00 : rs;
    e_rd  = rd;
    e_alu = alu;
    e_pc  = pc4;
    if (load && !aborted) e_rdata = rdata;
    if (aborted) e_err = 1'b1;
    check_w(tag);
    bus.dmem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive_m(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 32'd0);
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = 32'd0;
    model_reset();
    #1;
    chk("reset.req",   32'(bus.dmem_req), 32'd0);
    chk("reset.stall", 32'(bus.StallM),   32'd0);
    check_w("reset");
    @(negedge clk);
    drive_m(1'b1, 1'b0, 2'b01, 32'h100, 32'd0, 5'd3, 32'h4);
    #1;
    chk("reset_load.req", 32'(bus.dmem_req), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_txn("zw_load", 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 5'd5, 32'h1004, 0, 32'hCAFEBABE);
    run_txn("st3", 1'b0, 1'b1, 2'b00, 32'h40, 32'h12345678, 5'd0, 32'h1008, 3, 32'h0);
    run_txn("jal", 1'b1, 1'b0, 2'b10, 32'h55, 32'h0, 5'd1, 32'h2004, 0, 32'h0);
    run_txn("b2b_ld", 1'b1, 1'b0, 2'b01, 32'h200, 32'h0, 5'd7, 32'h3004, 0, 32'h11112222);
    run_txn("b2b_st", 1'b1, 1'b1, 2'b01, 32'h204, 32'hA5A5A5A5, 5'd8, 32'h3008, 0, 32'h0);
    run_txn("ld_max", 1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 5'd9, 32'h300C, MAXW, 32'h0BADF00D);
    run_txn("timeout", 1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 5'd10, 32'h4004, 100, 32'h0);

    drive_m(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("sticky.BusErr", 32'(bus.BusErr), 32'd1);

    // Reset in the middle of a wait.
    @(negedge clk);
    drive_m(1'b1, 1'b0, 2'b01, 32'h500, 32'h0, 5'd11, 32'h5004);
    bus.dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.req",   32'(bus.dmem_req), 32'd0);
    chk("midrst.stall", 32'(bus.StallM),   32'd0);
    check_w("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("post_rst", 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 5'd12, 32'h6004, 0, 32'hCAFEBABE);

    for (int i = 0; i < 80; i++) begin
      logic mw;
      logic [1:0] rs;
      mw = ($urandom_range(0, 3) == 0);
      rs = 2'($urandom_range(0, 3));
      run_txn("rand", 1'($urandom_range(0, 1)), mw, rs, $urandom(), $urandom(),
              5'($urandom_range(0, 31)), $urandom(), $urandom_range(0, MAXW + 2), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

`default_nettype wire
